// File: rtl/prog_loader.sv
// Boot-time program loader for the single-cycle RV32I core.
// The loader keeps the core in reset and accepts a byte stream: a 4-byte
// little-endian word count N, then N little-endian 32-bit words. It writes
// each word to instruction memory and then releases the core's reset.
module prog_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {HDR, DATA, FLUSH, RUN, ERR} loadStateT;

  loadStateT         state;
  loadStateT         stateNext;

  // One extra bit, so a full 2**ADDR_W image can be counted without wrapping.
  logic [ADDR_W:0]   wordIdx;
  logic [ADDR_W:0]   wordCnt;
  logic [1:0]        byteCnt;
  logic [23:0]       laneBuf;

  logic              accept;
  logic              lastByte;
  logic              lastWord;
  logic [31:0]       fullWord;

  // Assemble the in-flight word so its fourth byte can be used on the same edge.
  assign fullWord = {in_data, laneBuf};
  assign lastByte = (byteCnt == 2'd3);
  assign lastWord = ((wordIdx + (ADDR_W+1)'(1)) == wordCnt);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= stateNext;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    stateNext  = state;
    in_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    accept     = 1'b0;
    case (state)
      HDR: begin
        in_ready = !reset;
        accept   = in_valid && !reset;
        if (accept && lastByte) begin
          if (fullWord == 32'd0)                   stateNext = RUN;
          else if (fullWord > 32'(MAX_WORDS))      stateNext = ERR;
          else                                     stateNext = DATA;
        end
      end
      DATA: begin
        in_ready = !reset;
        accept   = in_valid && !reset;
        if (accept && lastByte && lastWord) stateNext = FLUSH;
      end
      FLUSH: stateNext = RUN;
      RUN: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      ERR: error = 1'b1;
      default: stateNext = HDR;
    endcase
  end

  // Byte packing, header latch, word counter and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      byteCnt   <= 2'd0;
      wordIdx   <= '0;
      wordCnt   <= '0;
      laneBuf   <= 24'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        byteCnt <= byteCnt + 2'd1;
        case (byteCnt)
          2'd0:    laneBuf[7:0]   <= in_data;
          2'd1:    laneBuf[15:8]  <= in_data;
          2'd2:    laneBuf[23:16] <= in_data;
          default: ;
        endcase
        if (lastByte) begin
          // Only the low bits are kept; anything wider has already sent us to ERR.
          if (state == HDR) wordCnt <= fullWord[ADDR_W:0];
          if (state == DATA) begin
            mem_we    <= 1'b1;
            mem_wdata <= fullWord;
            mem_addr  <= wordIdx[ADDR_W-1:0];
            wordIdx   <= wordIdx + (ADDR_W+1)'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: header handling, word packing,
// write timing, core reset release, error path and mid-load reset.
module tb_prog_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  int errors = 0;
  int checks = 0;

  // Write log filled from the memory port, sampled mid-cycle.
  int               wrCnt = 0;
  logic [ADDR_W-1:0] wrAddr [0:255];
  logic [31:0]       wrData [0:255];

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wrCnt < 256) begin
        wrAddr[wrCnt] = mem_addr;
        wrData[wrCnt] = mem_wdata;
      end
      wrCnt = wrCnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    sendByte(w[7:0]);
    sendByte(w[15:8]);
    sendByte(w[23:16]);
    sendByte(w[31:24]);
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    #1;
  endtask

  int base;
  int bad;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // ---- Reset state ----
    tick();
    tick();
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_error",      32'(error),      32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'd0);
    chk("rst_mem_wdata",  mem_wdata,       32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---- Test 1: N=2 back-to-back ----
    base = wrCnt;
    sendWord(32'd2);
    sendWord(32'h00500093);
    sendWord(32'h00100113);
    chk("t1_flush_we",    32'(mem_we),     32'd1);
    chk("t1_flush_addr",  32'(mem_addr),   32'd1);
    chk("t1_flush_data",  mem_wdata,       32'h00100113);
    chk("t1_flush_core",  32'(core_reset), 32'd1);
    chk("t1_flush_ready", 32'(in_ready),   32'd0);
    tick();
    chk("t1_run_core",  32'(core_reset), 32'd0);
    chk("t1_run_done",  32'(done),       32'd1);
    chk("t1_run_we",    32'(mem_we),     32'd0);
    chk("t1_nwrites",   32'(wrCnt - base), 32'd2);
    chk("t1_addr0", 32'(wrAddr[base]),   32'd0);
    chk("t1_data0", wrData[base],        32'h00500093);
    chk("t1_addr1", 32'(wrAddr[base+1]), 32'd1);
    chk("t1_data1", wrData[base+1],      32'h00100113);
    // Bytes offered in RUN are not taken and cause no write.
    in_valid = 1'b1; in_data = 8'h5A;
    tick(); tick();
    in_valid = 1'b0;
    chk("t1_run_ready",   32'(in_ready),     32'd0);
    chk("t1_run_nowrite", 32'(wrCnt - base), 32'd2);

    // ---- Test 6: reset while running ----
    reset = 1'b1;
    tick();
    chk("t6_core_reset", 32'(core_reset), 32'd1);
    chk("t6_done",       32'(done),       32'd0);
    chk("t6_ready_in_rst", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_ready_after", 32'(in_ready), 32'd1);

    // ---- Test 2: N=0 ----
    base = wrCnt;
    sendWord(32'd0);
    chk("t2_core_reset", 32'(core_reset), 32'd0);
    chk("t2_done",       32'(done),       32'd1);
    chk("t2_ready",      32'(in_ready),   32'd0);
    tick();
    chk("t2_nwrites",    32'(wrCnt - base), 32'd0);

    // ---- Test 3: N=65 -> error ----
    doReset();
    base = wrCnt;
    sendWord(32'd65);
    chk("t3_error",      32'(error),      32'd1);
    chk("t3_ready",      32'(in_ready),   32'd0);
    chk("t3_core_reset", 32'(core_reset), 32'd1);
    chk("t3_done",       32'(done),       32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_stuck_error", 32'(error),       32'd1);
    chk("t3_nwrites",     32'(wrCnt - base), 32'd0);

    // ---- High header byte set: all 32 bits count ----
    doReset();
    chk("hi_cleared_error", 32'(error), 32'd0);
    sendWord(32'h01000001);
    chk("hi_error", 32'(error),    32'd1);
    chk("hi_ready", 32'(in_ready), 32'd0);

    // ---- Test 4: N=3 with in_valid toggling ----
    doReset();
    base = wrCnt;
    begin
      logic [31:0] w4 [0:2];
      logic [31:0] hdr;
      w4[0] = 32'h44332211; w4[1] = 32'h88776655; w4[2] = 32'hCCBBAA99;
      hdr = 32'd3;
      for (int i = 0; i < 4; i++) begin
        sendByte(hdr[8*i +: 8]);
        tick();
      end
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 4; i++) begin
          sendByte(w4[k][8*i +: 8]);
          tick();
        end
      chk("t4_nwrites", 32'(wrCnt - base), 32'd3);
      for (int k = 0; k < 3; k++) begin
        chk("t4_addr", 32'(wrAddr[base+k]), 32'(k));
        chk("t4_data", wrData[base+k],      w4[k]);
      end
      chk("t4_done", 32'(done), 32'd1);
    end

    // ---- Test 5: reset mid-load, then reload ----
    doReset();
    base = wrCnt;
    sendWord(32'd2);
    sendWord(32'h11223344);
    sendByte(8'hAA);
    sendByte(8'hBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t5_partial_nwrites", 32'(wrCnt - base), 32'd1);
    chk("t5_core_reset",      32'(core_reset),   32'd1);
    sendWord(32'd1);
    sendWord(32'hDEADBEEF);
    tick();
    chk("t5_nwrites", 32'(wrCnt - base),   32'd2);
    chk("t5_addr",    32'(wrAddr[base+1]), 32'd0);
    chk("t5_data",    wrData[base+1],      32'hDEADBEEF);
    chk("t5_done",    32'(done),           32'd1);

    // ---- Full-depth image: N=64 ----
    doReset();
    base = wrCnt;
    sendWord(32'd64);
    chk("full_not_error", 32'(error), 32'd0);
    for (int k = 0; k < 64; k++) sendWord(32'hA5000000 | 32'(k));
    chk("full_last_core", 32'(core_reset), 32'd1);
    tick();
    chk("full_done",    32'(done),         32'd1);
    chk("full_nwrites", 32'(wrCnt - base), 32'd64);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (wrAddr[base+k] !== 6'(k) || wrData[base+k] !== (32'hA5000000 | 32'(k))) bad++;
    chk("full_contents", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
